// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receiver.
// Contents:
//   rx_state_e              - receiver FSM state encoding
//   PAR_NONE/PAR_EVEN/PAR_ODD - parity-mode selector values
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/rs232_baud_timer.sv
// Bit-period timer for the RS-232 receiver.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset
//   start - holds the count at 0
//   half  - selects the half-bit terminal count (CLKS_PER_BIT/2-1) instead of CLKS_PER_BIT-1
//   tick  - one-cycle pulse at the terminal count; the count wraps to 0 with it
module rs232_baud_timer #(
    parameter int unsigned CLKS_PER_BIT = 44
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic half,
    output logic tick
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TERM_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TERM_HALF = TW'(CLKS_PER_BIT / 2 - 1);

    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_term;

    assign w_term = half ? TERM_HALF : TERM_FULL;
    assign tick   = ~start & (r_cnt == w_term);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rs232_rx_param.sv
// Parameterised RS-232 receiver with ready/valid output and sticky overrun.
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   RX         - asynchronous serial input, idles high
//   rx_ready   - consumer accepts rx_data this cycle
//   ovr_clr    - clears the sticky overrun flag
//   rx_data    - received word
//   rx_valid   - rx_data, frame_err and parity_err are valid
//   frame_err  - a stop bit of the held word was sampled 0
//   parity_err - parity mismatch on the held word (0 when PARITY=0)
//   overrun    - sticky: a completed frame was dropped
module rs232_rx_param
    import rs232_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 44,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 rx_ready,
    input  logic                 ovr_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("rs232_rx_param: CLKS_PER_BIT must be 4 or more");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("rs232_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_par
        $error("rs232_rx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("rs232_rx_param: STOP_BITS must be 1 or 2");
    end
    if (MSB_FIRST > 1) begin : g_bad_order
        $error("rs232_rx_param: MSB_FIRST must be 0 or 1");
    end

    localparam int unsigned BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    // Synchronizer, edge history and warm-up counter. The warm-up keeps the
    // forced-high reset value of the synchronizer from looking like a falling
    // edge when the line is already low after reset.
    logic       r_rx_s1;
    logic       r_rx_s2;
    logic       r_rx_prev;
    logic [1:0] r_warm;
    logic       w_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_warm    <= 2'd0;
        end else begin
            r_rx_s1   <= RX;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    assign w_fall = (r_warm == 2'd3) & r_rx_prev & ~r_rx_s2;

    // Bit timer
    logic w_tick;
    logic w_timer_start;
    logic w_half;

    rs232_baud_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_timer (
        .clk  (clk),
        .rst  (rst),
        .start(w_timer_start),
        .half (w_half),
        .tick (w_tick)
    );

    // FSM
    rx_state_e r_state;
    rx_state_e w_state_next;
    logic      w_done;

    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_par_bit;
    logic                 r_ferr_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_timer_start = 1'b0;
        w_half        = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_start = 1'b1;
                if (w_fall) begin
                    w_state_next = START;
                end
            end
            START: begin
                w_half = 1'b1;
                if (w_tick) begin
                    // A high sample at mid start bit is a glitch.
                    w_state_next = r_rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick && r_bit_cnt == LAST_DATA) begin
                    w_state_next = (PARITY != PAR_NONE) ? PAR : STOP;
                end
            end
            PAR: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick && r_bit_cnt == LAST_STOP) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr_acc <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_bit_cnt  <= '0;
                    r_ferr_acc <= 1'b0;
                end
                DATA: begin
                    if (w_tick) begin
                        if (MSB_FIRST != 0) begin
                            r_shreg <= {r_shreg[DATA_BITS-2:0], r_rx_s2};
                        end else begin
                            r_shreg <= {r_rx_s2, r_shreg[DATA_BITS-1:1]};
                        end
                        r_bit_cnt <= (r_bit_cnt == LAST_DATA) ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_par_bit <= r_rx_s2;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (!r_rx_s2) begin
                            r_ferr_acc <= 1'b1;
                        end
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                default: begin
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // Status of the frame completing this cycle; the final stop sample is
    // still on the synchronizer output, not yet in the accumulator.
    logic w_xor;
    logic w_perr;
    logic w_ferr;

    assign w_xor  = (^r_shreg) ^ r_par_bit;
    assign w_perr = (PARITY == PAR_EVEN) ? w_xor :
                    (PARITY == PAR_ODD)  ? ~w_xor : 1'b0;
    assign w_ferr = r_ferr_acc | ~r_rx_s2;

    // Output holding register and handshake
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_ovr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_perr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_done && (!r_valid || rx_ready)) begin
                r_data  <= r_shreg;
                r_valid <= 1'b1;
                r_ferr  <= w_ferr;
                r_perr  <= w_perr;
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end

            // Set beats clear when both happen together.
            if (w_done && r_valid && !rx_ready) begin
                r_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign frame_err  = r_ferr;
    assign parity_err = r_perr;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_rs232_rx_param.sv
// Self-checking bench for rs232_rx_param: an 8N1 instance and an even-parity
// instance, each with a scoreboard queue popped on every rx_valid/rx_ready handshake.
module tb_rs232_rx_param;

    localparam int CPB = 44;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       rx_a = 1'b1, ready_a = 1'b1, ovr_clr_a = 1'b0;
    logic [7:0] data_a;
    logic       valid_a, ferr_a, perr_a, ovr_a;

    logic       rx_p = 1'b1, ready_p = 1'b1, ovr_clr_p = 1'b0;
    logic [7:0] data_p;
    logic       valid_p, ferr_p, perr_p, ovr_p;

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv_a = 0;
    int n_deliv_p = 0;

    exp_t q_a[$];
    exp_t q_p[$];

    always #10 clk = ~clk;

    rs232_rx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .MSB_FIRST(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .RX(rx_a), .rx_ready(ready_a), .ovr_clr(ovr_clr_a),
        .rx_data(data_a), .rx_valid(valid_a), .frame_err(ferr_a), .parity_err(perr_a),
        .overrun(ovr_a)
    );

    rs232_rx_param #(
        .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)
    ) u_dut_p (
        .clk(clk), .rst(rst), .RX(rx_p), .rx_ready(ready_p), .ovr_clr(ovr_clr_p),
        .rx_data(data_p), .rx_valid(valid_p), .frame_err(ferr_p), .parity_err(perr_p),
        .overrun(ovr_p)
    );

    // Scoreboard monitors: a handshake seen here is consumed on the next rising edge.
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (valid_a && ready_a) begin
            n_deliv_a++;
            n_tests++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL deliver_a: unexpected word data=%h ferr=%b perr=%b",
                         data_a, ferr_a, perr_a);
            end else begin
                e = q_a.pop_front();
                if ({data_a, ferr_a, perr_a} !== {e.data, e.ferr, e.perr}) begin
                    n_fail++;
                    $display("FAIL deliver_a: got data=%h ferr=%b perr=%b want data=%h ferr=%b perr=%b",
                             data_a, ferr_a, perr_a, e.data, e.ferr, e.perr);
                end
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (valid_p && ready_p) begin
            n_deliv_p++;
            n_tests++;
            if (q_p.size() == 0) begin
                n_fail++;
                $display("FAIL deliver_p: unexpected word data=%h ferr=%b perr=%b",
                         data_p, ferr_p, perr_p);
            end else begin
                e = q_p.pop_front();
                if ({data_p, ferr_p, perr_p} !== {e.data, e.ferr, e.perr}) begin
                    n_fail++;
                    $display("FAIL deliver_p: got data=%h ferr=%b perr=%b want data=%h ferr=%b perr=%b",
                             data_p, ferr_p, perr_p, e.data, e.ferr, e.perr);
                end
            end
        end
    end

    task automatic wait_bits(input int nbits);
        repeat (nbits * CPB) @(negedge clk);
    endtask

    // Drives start, data LSB first, optional parity, one stop bit, then idle high.
    task automatic send_frame(input bit sel_p, input logic [7:0] data,
                              input logic par_bit, input logic stop_bit);
        logic [10:0] bits;
        int          n;
        if (sel_p) begin
            bits = {stop_bit, par_bit, data, 1'b0};
            n    = 11;
        end else begin
            bits = {1'b0, stop_bit, data, 1'b0};
            n    = 10;
        end
        for (int i = 0; i < n; i++) begin
            if (sel_p) rx_p = bits[i];
            else       rx_a = bits[i];
            repeat (CPB) @(negedge clk);
        end
        if (sel_p) rx_p = 1'b1;
        else       rx_a = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({data_a, valid_a, ferr_a, perr_a, ovr_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_a: got data=%h v=%b f=%b p=%b o=%b want all 0",
                     data_a, valid_a, ferr_a, perr_a, ovr_a);
        end
        n_tests++;
        if ({data_p, valid_p, ferr_p, perr_p, ovr_p} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_p: got data=%h v=%b f=%b p=%b o=%b want all 0",
                     data_p, valid_p, ferr_p, perr_p, ovr_p);
        end
        wait_bits(2);
    endtask

    task automatic test_basic;
        int d0;
        d0 = n_deliv_a;
        q_a.push_back('{data: 8'h19, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b0, 8'h19, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (n_deliv_a - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulses: got %0d deliveries want 1", n_deliv_a - d0);
        end
        n_tests++;
        if (valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_valid_drop: got rx_valid=%b want 0", valid_a);
        end
    endtask

    task automatic test_overrun;
        ready_a = 1'b0;
        q_a.push_back('{data: 8'h19, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b0, 8'h19, 1'b0, 1'b1);
        wait_bits(1);
        send_frame(1'b0, 8'h10, 1'b0, 1'b1);
        wait_bits(1);
        n_tests++;
        if ({valid_a, data_a, ovr_a} !== {1'b1, 8'h19, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got v=%b data=%h ovr=%b want v=1 data=19 ovr=1",
                     valid_a, data_a, ovr_a);
        end
        ovr_clr_a = 1'b1;
        @(negedge clk);
        ovr_clr_a = 1'b0;
        n_tests++;
        if ({valid_a, ovr_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL overrun_clear: got v=%b ovr=%b want v=1 ovr=0", valid_a, ovr_a);
        end
        ready_a = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (q_a.size() != 0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_drain: got pending=%0d v=%b want pending=0 v=0",
                     q_a.size(), valid_a);
        end
    endtask

    task automatic test_glitch;
        int d0;
        d0 = n_deliv_a;
        rx_a = 1'b0;
        repeat (10) @(negedge clk);
        rx_a = 1'b1;
        wait_bits(3);
        n_tests++;
        if (n_deliv_a != d0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_none: got deliveries=%0d v=%b want 0 and 0",
                     n_deliv_a - d0, valid_a);
        end
        q_a.push_back('{data: 8'h10, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b0, 8'h10, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (q_a.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_after: got pending=%0d want 0", q_a.size());
        end
    endtask

    task automatic test_frame_err;
        q_a.push_back('{data: 8'hA5, ferr: 1'b1, perr: 1'b0});
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        wait_bits(2);
        n_tests++;
        if (ferr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_err_set: got frame_err=%b want 1", ferr_a);
        end
        q_a.push_back('{data: 8'h3C, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b0, 8'h3C, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (ferr_a !== 1'b0 || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL frame_err_clear: got frame_err=%b pending=%0d want 0 and 0",
                     ferr_a, q_a.size());
        end
    endtask

    // 0x07 has three ones, so even parity needs parity bit 1.
    task automatic test_parity;
        q_p.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        send_frame(1'b1, 8'h07, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (perr_p !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: got parity_err=%b want 1", perr_p);
        end
        q_p.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b1, 8'h07, 1'b1, 1'b1);
        wait_bits(2);
        n_tests++;
        if (perr_p !== 1'b0 || q_p.size() != 0) begin
            n_fail++;
            $display("FAIL parity_good: got parity_err=%b pending=%0d want 0 and 0",
                     perr_p, q_p.size());
        end
        q_p.push_back('{data: 8'hC3, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b1, 8'hC3, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (q_p.size() != 0) begin
            n_fail++;
            $display("FAIL parity_even_word: got pending=%0d want 0", q_p.size());
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] part;
        int         d0;
        // Load a held word with frame_err and overrun so reset has state to clear.
        ready_a = 1'b0;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
        wait_bits(1);
        send_frame(1'b0, 8'h44, 1'b0, 1'b1);
        wait_bits(1);
        n_tests++;
        if ({valid_a, ferr_a, ovr_a} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got v=%b f=%b o=%b want 1 1 1",
                     valid_a, ferr_a, ovr_a);
        end
        // Start bit then data bits 1,1,0 of 0x33, leaving the line low.
        part = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            rx_a = part[i];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({data_a, valid_a, ferr_a, perr_a, ovr_a} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got data=%h v=%b f=%b p=%b o=%b want all 0",
                     data_a, valid_a, ferr_a, perr_a, ovr_a);
        end
        d0 = n_deliv_a;
        wait_bits(3);
        rx_a    = 1'b1;
        ready_a = 1'b1;
        wait_bits(12);
        n_tests++;
        if (n_deliv_a != d0 || valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_nodeliver: got deliveries=%0d v=%b want 0 and 0",
                     n_deliv_a - d0, valid_a);
        end
        q_a.push_back('{data: 8'h6E, ferr: 1'b0, perr: 1'b0});
        send_frame(1'b0, 8'h6E, 1'b0, 1'b1);
        wait_bits(2);
        n_tests++;
        if (q_a.size() != 0 || data_a !== 8'h6E) begin
            n_fail++;
            $display("FAIL reset_mid_after: got pending=%0d data=%h want 0 and 6e",
                     q_a.size(), data_a);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_glitch();
        test_frame_err();
        test_parity();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
